// File: rtl/decode_stage_pkg.sv
// Shared RISC-V decode types: instruction views, format codes and the
// decoded-instruction record passed from decode to execute.
package riscv;

    typedef logic [31:0] pc_t;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] imm_t;

    typedef enum logic [6:0] {
        LOAD   = 7'h03,
        OP_IMM = 7'h13,
        AUIPC  = 7'h17,
        STORE  = 7'h23,
        OP     = 7'h33,
        LUI    = 7'h37,
        BRANCH = 7'h63,
        JALR   = 7'h67,
        JAL    = 7'h6F
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        reg_t       rs2;
        reg_t       rs1;
        logic [2:0] funct3;
        reg_t       rd;
        logic [6:0] opcode;
    } ir_r_t;

    typedef struct packed {
        logic [11:0] imm_11_0;
        reg_t        rs1;
        logic [2:0]  funct3;
        reg_t        rd;
        logic [6:0]  opcode;
    } ir_i_t;

    typedef struct packed {
        logic [6:0] imm_11_5;
        reg_t       rs2;
        reg_t       rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4_0;
        logic [6:0] opcode;
    } ir_s_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10_5;
        reg_t       rs2;
        reg_t       rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4_1;
        logic       imm_11;
        logic [6:0] opcode;
    } ir_sb_t;

    typedef struct packed {
        logic [19:0] imm_31_12;
        reg_t        rd;
        logic [6:0]  opcode;
    } ir_u_t;

    typedef struct packed {
        logic        imm_20;
        logic [9:0]  imm_10_1;
        logic        imm_11;
        logic [7:0]  imm_19_12;
        reg_t        rd;
        logic [6:0]  opcode;
    } ir_uj_t;

    typedef union packed {
        ir_r_t  r;
        ir_i_t  i;
        ir_s_t  s;
        ir_sb_t sb;
        ir_u_t  u;
        ir_uj_t uj;
    } ir_t;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5,
        FMT_X  = 3'd6
    } fmt_t;

    typedef struct packed {
        pc_t        pc;
        logic [6:0] opcode;
        fmt_t       fmt;
        reg_t       rd;
        reg_t       rs1;
        reg_t       rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        imm_t       imm;
        logic       illegal;
    } decoded_t;

    // Decode of addi x0,x0,0 at address 0; the payload seen after reset.
    localparam decoded_t NOP_DEC = '{
        pc:      '0,
        opcode:  OP_IMM,
        fmt:     FMT_I,
        rd:      '0,
        rs1:     '0,
        rs2:     '0,
        funct3:  '0,
        funct7:  '0,
        imm:     '0,
        illegal: 1'b0
    };

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
interface decode_stage_if;
    import riscv::*;

    logic     in_valid;
    logic     in_ready;
    ir_t      in_ir;
    pc_t      in_pc;
    logic     out_valid;
    logic     out_ready;
    decoded_t out_dec;

    // Decode stage side
    modport slave (
        input  in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_dec
    );

    // Surrounding pipeline side (fetch producer / execute consumer)
    modport master (
        output in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_dec
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate builder.
module imm_gen
    import riscv::*;
(
    input  ir_t  ir,
    output fmt_t fmt,
    output imm_t imm,
    output logic illegal
);

    // Classify the opcode and assemble the immediate for that format
    always_comb begin
        fmt     = FMT_X;
        imm     = '0;
        illegal = 1'b0;
        case (ir.r.opcode)
            OP: begin
                fmt = FMT_R;
            end
            OP_IMM, LOAD, JALR: begin
                fmt = FMT_I;
                imm = {{20{ir.i.imm_11_0[11]}}, ir.i.imm_11_0};
            end
            STORE: begin
                fmt = FMT_S;
                imm = {{20{ir.s.imm_11_5[6]}}, ir.s.imm_11_5, ir.s.imm_4_0};
            end
            BRANCH: begin
                fmt = FMT_SB;
                imm = {{19{ir.sb.imm_12}}, ir.sb.imm_12, ir.sb.imm_11,
                       ir.sb.imm_10_5, ir.sb.imm_4_1, 1'b0};
            end
            LUI, AUIPC: begin
                fmt = FMT_U;
                imm = {ir.u.imm_31_12, 12'b0};
            end
            JAL: begin
                fmt = FMT_UJ;
                imm = {{11{ir.uj.imm_20}}, ir.uj.imm_20, ir.uj.imm_19_12,
                       ir.uj.imm_11, ir.uj.imm_10_1, 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes one instruction per cycle into a main
// output register, with a skid register absorbing one extra instruction
// under backpressure so fetch never sees a combinational ready path.
module decode_stage
    import riscv::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    decode_stage_if.slave  io
);

    fmt_t     in_fmt;
    imm_t     in_imm;
    logic     in_illegal;
    decoded_t in_dec;

    decoded_t main_d, main_q;
    decoded_t skid_d, skid_q;
    logic     main_valid_d, main_valid_q;
    logic     skid_valid_d, skid_valid_q;
    logic     accept;
    logic     main_load;

    imm_gen u_imm_gen (
        .ir      (io.in_ir),
        .fmt     (in_fmt),
        .imm     (in_imm),
        .illegal (in_illegal)
    );

    // Assemble the decoded record; register fields come from the R view unconditionally
    always_comb begin
        in_dec = '{
            pc:      io.in_pc,
            opcode:  io.in_ir.r.opcode,
            fmt:     in_fmt,
            rd:      io.in_ir.r.rd,
            rs1:     io.in_ir.r.rs1,
            rs2:     io.in_ir.r.rs2,
            funct3:  io.in_ir.r.funct3,
            funct7:  io.in_ir.r.funct7,
            imm:     in_imm,
            illegal: in_illegal
        };
    end

    // Next-state of main/skid buffers; flush empties both and drops the offered input
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        accept       = io.in_valid & ~skid_valid_q & ~flush;
        main_load    = ~main_valid_q | io.out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            // A full skid implies in_ready was low, so no accept can collide here
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_dec;
            skid_valid_d = 1'b1;
        end
    end

    // Buffer registers; reset empties the stage and parks the payload on the NOP decode
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= NOP_DEC;
            skid_q       <= NOP_DEC;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign io.in_ready  = ~skid_valid_q;
    assign io.out_valid = main_valid_q;
    assign io.out_dec   = main_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode cases, backpressure
// and flush scenarios, then randomized traffic against a queue-based model.
module tb_decode_stage;
    import riscv::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instructions held by the stage, oldest first (at most two)
    decoded_t model_q[$];
    decoded_t nop_exp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decoder written with shifts/masks on the raw word
    function automatic decoded_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        decoded_t          d;
        logic signed [31:0] sir;
        logic [31:0]       a20, a19, a11;
        sir = ir;
        a20 = sir >>> 20;
        a19 = sir >>> 19;
        a11 = sir >>> 11;
        d.pc      = pc;
        d.opcode  = ir[6:0];
        d.rd      = ir[11:7];
        d.funct3  = ir[14:12];
        d.rs1     = ir[19:15];
        d.rs2     = ir[24:20];
        d.funct7  = ir[31:25];
        d.illegal = 1'b0;
        d.imm     = '0;
        case (ir[6:0])
            7'h33: d.fmt = FMT_R;
            7'h13, 7'h03, 7'h67: begin
                d.fmt = FMT_I;
                d.imm = a20;
            end
            7'h23: begin
                d.fmt = FMT_S;
                d.imm = (a20 & ~32'h1F) | ((ir >> 7) & 32'h1F);
            end
            7'h63: begin
                d.fmt = FMT_SB;
                d.imm = (a19 & 32'hFFFF_F000) | ((ir << 4) & 32'h800)
                      | ((ir >> 20) & 32'h7E0) | ((ir >> 7) & 32'h1E);
            end
            7'h37, 7'h17: begin
                d.fmt = FMT_U;
                d.imm = ir & 32'hFFFF_F000;
            end
            7'h6F: begin
                d.fmt = FMT_UJ;
                d.imm = (a11 & 32'hFFF0_0000) | (ir & 32'h000F_F000)
                      | ((ir >> 9) & 32'h800) | ((ir >> 20) & 32'h7FE);
            end
            default: begin
                d.fmt     = FMT_X;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rst);
        bus.in_valid  = v;
        bus.in_ir     = ir;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rst;
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            int sz;
            sz = model_q.size();
            if (sz > 0 && ordy) void'(model_q.pop_front());
            if (v && sz < 2) model_q.push_back(ref_decode(ir, pc));
        end
        #1;
        check("out_valid", 128'(bus.out_valid), 128'(model_q.size() > 0));
        check("in_ready", 128'(bus.in_ready), 128'(model_q.size() < 2));
        if (model_q.size() > 0)
            check("out_dec", 128'(bus.out_dec), 128'(model_q[0]));
        if (rst)
            check("reset_payload", 128'(bus.out_dec), 128'(nop_exp));
    endtask

    logic [31:0] d_ir  [5] = '{32'hFFF0_0013, 32'h8000_0063, 32'h0020_006F, 32'h1234_5037, 32'hFFFF_FFFF};
    logic [31:0] d_imm [5] = '{32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0000_0002, 32'h1234_5000, 32'h0000_0000};
    fmt_t        d_fmt [5] = '{FMT_I, FMT_SB, FMT_UJ, FMT_U, FMT_X};
    logic        d_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0]  ops   [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

    initial begin
        logic [31:0] r, ir;
        logic [6:0]  op;

        nop_exp = ref_decode(32'h0000_0013, 32'h0);
        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b1;

        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Directed decode cases at full throughput
        for (int i = 0; i < 5; i++) begin
            step(1'b1, d_ir[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            check("dir_imm", 128'(bus.out_dec.imm), 128'(d_imm[i]));
            check("dir_fmt", 128'(bus.out_dec.fmt), 128'(d_fmt[i]));
            check("dir_illegal", 128'(bus.out_dec.illegal), 128'(d_ill[i]));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A then B while stalled, then drain in order
        step(1'b1, 32'h0010_0093, 32'hA00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0113, 32'hB00, 1'b0, 1'b0, 1'b0);
        check("bp_head_pc", 128'(bus.out_dec.pc), 128'(32'hA00));
        step(1'b1, 32'h0030_0193, 32'hC00, 1'b1, 1'b0, 1'b0);
        check("bp_second_pc", 128'(bus.out_dec.pc), 128'(32'hB00));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with A in main, B in skid, C offered
        step(1'b1, 32'h0010_0093, 32'hA10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0113, 32'hB10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0030_0193, 32'hC10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            r  = $urandom();
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 8)] : r[6:0];
            ir = {r[31:7], op};
            step($urandom_range(0, 9) < 7, ir, $urandom(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
